rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the register file's single write port.
- Shares that port between the in-order WB stage and the multi-cycle MUL/DIV unit (MDU), which returns results out of band.
- MDU results are buffered in a small FIFO. WB has default priority; an anti-starvation counter guarantees the MDU drains.
- When the FIFO head takes the port from a valid WB write, the block stalls the pipeline.

Parameters:
- XLEN, 32, data width
- FIFO_DEPTH, 2, MDU result buffer entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive lost arbitrations before the FIFO head is forced to win (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wb_reg_write_en_in  in  1  WB stage requests a register write
- wb_rd_addr_in  in  5  WB destination register
- wb_write_data_in  in  XLEN  WB write data (ALU, load or PC+4, already muxed)
- mdu_valid_in  in  1  MDU result valid
- mdu_rd_addr_in  in  5  MDU destination register
- mdu_data_in  in  XLEN  MDU result
- mdu_ready_out  out  1  block accepts the MDU result this cycle
- wb_stall_out  out  1  WB write not taken; pipeline must hold MEM/WB and all earlier stages
- rf_write_en_out  out  1  register file write enable
- rf_rd_addr_out  out  5  register file write address
- rf_write_data_out  out  XLEN  register file write data
- fifo_count_out  out  $clog2(FIFO_DEPTH)+1  buffered MDU results

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. On the first edge with rst_n=0:
  - FIFO is emptied; buffered results are discarded.
  - starve_cnt is set to 0.
  - rf_write_en_out, rf_rd_addr_out and rf_write_data_out are set to 0.
  - fifo_count_out is 0.
- Outputs while rst_n=0: mdu_ready_out=0 and wb_stall_out=0, forced combinationally.
- Handshake: mdu_ready_out = !full.
  - Transfer occurs when mdu_valid_in && mdu_ready_out.
  - Results with rd=0 are accepted but not enqueued.
  - Full with a simultaneous dequeue still gives ready=0 (no bypass).
- Requests:
  - wb_req = wb_reg_write_en_in && wb_rd_addr_in!=0.
  - fifo_req = FIFO non-empty.
  - The MDU input never bypasses the FIFO: minimum MDU-to-RF latency is 2 cycles (enqueue edge, then arbitration edge).
- Grant, combinational per cycle:
  - fifo_req && (!wb_req || starve_cnt>=STARVE_LIMIT) -> FIFO head wins. Otherwise wb_req -> WB wins. Otherwise no write.
- Stall: wb_stall_out = wb_req && FIFO granted. WB inputs are held stable by the pipeline until taken.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, when fifo_req && WB granted.
  - Clears to 0 when the FIFO head is granted or the FIFO is empty.
- Write port:
  - Registered; the winner appears on rf_*_out on the edge after the grant cycle (1-cycle latency).
  - rf_write_en_out=0 when there is no grant; address and data then hold their previous values.
- FIFO pointers: wrap modulo FIFO_DEPTH. Simultaneous enqueue and dequeue leaves the count unchanged.
- Ordering: WAW ordering between MDU and pipeline results is enforced upstream by the hazard unit; this block does not check it.
- x0 is never written: rf_write_en_out never rises with rf_rd_addr_out=0.

Decomposition:
- Shared package rv_pipe_pkg holds XLEN, REG_ADDR_W=5 and REG_X0=5'd0.
- One sub-module, wb_result_fifo: parametrised synchronous FIFO with push/pop/full/empty/count. The arbitration and starve-counter logic stay in the top module.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, rst_n=0 for 1 cycle -> fifo_count_out=0, rf_write_en_out=0, no buffered write ever appears.
- WB only: wb_reg_write_en_in=1, rd=5, data=0xDEADBEEF -> next cycle rf_write_en_out=1, rf_rd_addr_out=5, data 0xDEADBEEF, wb_stall_out=0 throughout.
- MDU only: one MDU result rd=7, data=0x12 -> ready=1, count goes to 1, RF write of x7=0x12 two edges after the handshake, count returns to 0.
- Starvation:
  - Stimulus: WB requests every cycle (rd=1..n); one MDU entry buffered.
  - Required: exactly 4 WB writes, then wb_stall_out=1 for one cycle and the MDU entry is written; the held WB write follows on the next cycle.
- Full: 3 back-to-back MDU results while WB is busy -> third sees mdu_ready_out=0 and is held until a pop; no entry lost or duplicated.
- x0 drop: WB rd=0 and MDU rd=0 with valid data -> no rf_write_en_out pulse, MDU handshake completes, count stays 0, wb_stall_out=0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: data width, register-address width and the
// write-port grant encoding used by the register-file write arbiter.
package rv_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_FIFO = 2'd2
  } gnt_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering MDU results until they win the RF write port.
// Pushes while full and pops while empty are ignored.
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_in,
  input  logic                     pop_in,
  input  logic [WIDTH-1:0]         wdata_in,
  output logic [WIDTH-1:0]         rdata_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_out  = (count_q == CNT_W'(DEPTH));
  assign empty_out = (count_q == {CNT_W{1'b0}});
  assign count_out = count_q;
  assign rdata_out = mem_q[rd_ptr_q];
  assign do_push   = push_in && !full_out;
  assign do_pop    = pop_in && !empty_out;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register file's single write port, sharing it between the WB stage
// and buffered MDU results; WB has priority until the MDU head is starved.
module rf_write_arbiter
  import rv_pipe_pkg::*;
#(
  parameter int XLEN         = rv_pipe_pkg::XLEN,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wb_reg_write_en_in,
  input  logic [REG_ADDR_W-1:0]       wb_rd_addr_in,
  input  logic [XLEN-1:0]             wb_write_data_in,
  input  logic                        mdu_valid_in,
  input  logic [REG_ADDR_W-1:0]       mdu_rd_addr_in,
  input  logic [XLEN-1:0]             mdu_data_in,
  output logic                        mdu_ready_out,
  output logic                        wb_stall_out,
  output logic                        rf_write_en_out,
  output logic [REG_ADDR_W-1:0]       rf_rd_addr_out,
  output logic [XLEN-1:0]             rf_write_data_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);

  localparam int ENTRY_W  = REG_ADDR_W + XLEN;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  wb_req;
  logic                  fifo_req;
  logic                  starved;
  gnt_e                  grant;

  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;

  // Results addressed to x0 complete the handshake but are never buffered.
  assign fifo_push = mdu_valid_in && mdu_ready_out && (mdu_rd_addr_in != REG_X0);
  assign fifo_pop  = (grant == GNT_FIFO);

  wb_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_in   (fifo_push),
    .pop_in    (fifo_pop),
    .wdata_in  ({mdu_rd_addr_in, mdu_data_in}),
    .rdata_out (fifo_head),
    .full_out  (fifo_full),
    .empty_out (fifo_empty),
    .count_out (fifo_count_out)
  );

  // Per-cycle grant: WB by default, FIFO head when WB is idle or it is starved.
  always_comb begin
    wb_req   = wb_reg_write_en_in && (wb_rd_addr_in != REG_X0);
    fifo_req = !fifo_empty;
    starved  = (starve_cnt_q >= STARVE_W'(STARVE_LIMIT));
    if (fifo_req && (!wb_req || starved)) begin
      grant = GNT_FIFO;
    end else if (wb_req) begin
      grant = GNT_WB;
    end else begin
      grant = GNT_NONE;
    end
  end

  // Handshake and stall are forced low while reset is asserted.
  always_comb begin
    mdu_ready_out = rst_n && !fifo_full;
    wb_stall_out  = rst_n && wb_req && (grant == GNT_FIFO);
  end

  // Next write-port contents and starvation count; address/data hold when idle.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_data_d    = rf_data_q;
    starve_cnt_d = {STARVE_W{1'b0}};
    case (grant)
      GNT_FIFO: begin
        rf_we_d      = 1'b1;
        rf_rd_d      = fifo_head[ENTRY_W-1 -: REG_ADDR_W];
        rf_data_d    = fifo_head[XLEN-1:0];
        starve_cnt_d = {STARVE_W{1'b0}};
      end
      GNT_WB: begin
        rf_we_d   = 1'b1;
        rf_rd_d   = wb_rd_addr_in;
        rf_data_d = wb_write_data_in;
        if (fifo_req && !starved) begin
          starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end else if (fifo_req) begin
          starve_cnt_d = starve_cnt_q;
        end else begin
          starve_cnt_d = {STARVE_W{1'b0}};
        end
      end
      GNT_NONE: begin
        rf_we_d      = 1'b0;
        starve_cnt_d = {STARVE_W{1'b0}};
      end
      default: begin
        rf_we_d      = 1'b0;
        starve_cnt_d = {STARVE_W{1'b0}};
      end
    endcase
  end

  // Registered write port and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= {STARVE_W{1'b0}};
      rf_we_q      <= 1'b0;
      rf_rd_q      <= {REG_ADDR_W{1'b0}};
      rf_data_q    <= {XLEN{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign rf_write_en_out   = rf_we_q;
  assign rf_rd_addr_out    = rf_rd_q;
  assign rf_write_data_out = rf_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, hand-written
// starvation/reset sequences, then random traffic against a queue-based model.
module tb_rf_write_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_v;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [1:0]  fifo_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .XLEN         (XLEN),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wb_reg_write_en_in (wb_en),
    .wb_rd_addr_in      (wb_rd),
    .wb_write_data_in   (wb_data),
    .mdu_valid_in       (mdu_v),
    .mdu_rd_addr_in     (mdu_rd),
    .mdu_data_in        (mdu_data),
    .mdu_ready_out      (mdu_ready),
    .wb_stall_out       (wb_stall),
    .rf_write_en_out    (rf_we),
    .rf_rd_addr_out     (rf_rd),
    .rf_write_data_out  (rf_data),
    .fifo_count_out     (fifo_cnt)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        e_ready;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    int          e_cnt;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    wb_en = wen; wb_rd = wrd; wb_data = wdata;
    mdu_v = mv; mdu_rd = mrd; mdu_data = mdata;
  endtask

  // Combinational outputs, sampled mid-cycle.
  task automatic check_pre(input string tag, input logic e_ready, input logic e_stall);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(mdu_ready), 32'(e_ready));
    chk({tag, ".stall"}, 32'(wb_stall), 32'(e_stall));
  endtask

  // Registered outputs, sampled just after the active edge.
  task automatic check_post(input string tag, input logic e_we, input logic [4:0] e_rd,
                            input logic [31:0] e_data, input int e_cnt);
    @(posedge clk);
    #1;
    chk({tag, ".we"}, 32'(rf_we), 32'(e_we));
    chk({tag, ".rd"}, 32'(rf_rd), 32'(e_rd));
    chk({tag, ".data"}, rf_data, e_data);
    chk({tag, ".cnt"}, 32'(fifo_cnt), 32'(e_cnt));
  endtask

  vec_t tbl[17];
  ent_t mq[$];
  int   m_starve;
  logic m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  initial begin
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12, 1'b1, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 1};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b1, 5'd7,  32'h12,       0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b0, 5'd7,  32'h12,       0};
    tbl[5]  = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd0,  32'h66, 1'b1, 1'b0, 1'b0, 5'd7,  32'h12,       0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b0, 5'd7,  32'h12,       0};
    tbl[7]  = '{1'b1, 5'd1,  32'h101,      1'b1, 5'd10, 32'hA0, 1'b1, 1'b0, 1'b1, 5'd1,  32'h101,      1};
    tbl[8]  = '{1'b1, 5'd2,  32'h102,      1'b1, 5'd11, 32'hA1, 1'b1, 1'b0, 1'b1, 5'd2,  32'h102,      2};
    tbl[9]  = '{1'b1, 5'd3,  32'h103,      1'b1, 5'd12, 32'hA2, 1'b0, 1'b0, 1'b1, 5'd3,  32'h103,      2};
    tbl[10] = '{1'b1, 5'd4,  32'h104,      1'b1, 5'd12, 32'hA2, 1'b0, 1'b0, 1'b1, 5'd4,  32'h104,      2};
    tbl[11] = '{1'b1, 5'd5,  32'h105,      1'b1, 5'd12, 32'hA2, 1'b0, 1'b0, 1'b1, 5'd5,  32'h105,      2};
    tbl[12] = '{1'b1, 5'd6,  32'h106,      1'b1, 5'd12, 32'hA2, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA0,       1};
    tbl[13] = '{1'b1, 5'd6,  32'h106,      1'b1, 5'd12, 32'hA2, 1'b1, 1'b0, 1'b1, 5'd6,  32'h106,      2};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 1'b1, 5'd11, 32'hA1,       1};
    tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b1, 5'd12, 32'hA2,       0};
    tbl[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b0, 5'd12, 32'hA2,       0};

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_pre("rst", 1'b0, 1'b0);
    check_post("rst", 1'b0, 5'd0, 32'h0, 0);
    rst_n = 1'b1;

    // Directed vector table: WB only, MDU only, x0 drop, full FIFO with starvation.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].wen, tbl[i].wrd, tbl[i].wdata, tbl[i].mv, tbl[i].mrd, tbl[i].mdata);
      check_pre($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_stall);
      check_post($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_rd, tbl[i].e_data, tbl[i].e_cnt);
    end

    // Starvation: exactly LIMIT WB writes, then the buffered MDU entry, then held WB.
    drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd9, 32'h99);
    check_pre("starve_fill", 1'b1, 1'b0);
    check_post("starve_fill", 1'b1, 5'd1, 32'h201, 1);
    for (int k = 2; k < 2 + LIMIT; k++) begin
      drive(1'b1, 5'(k), 32'h200 + 32'(k), 1'b0, 5'd0, 32'h0);
      check_pre($sformatf("starve_wb%0d", k), 1'b1, 1'b0);
      check_post($sformatf("starve_wb%0d", k), 1'b1, 5'(k), 32'h200 + 32'(k), 1);
    end
    drive(1'b1, 5'd6, 32'h206, 1'b0, 5'd0, 32'h0);
    check_pre("starve_win", 1'b1, 1'b1);
    check_post("starve_win", 1'b1, 5'd9, 32'h99, 0);
    check_pre("starve_held", 1'b1, 1'b0);
    check_post("starve_held", 1'b1, 5'd6, 32'h206, 0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_pre("starve_idle", 1'b1, 1'b0);
    check_post("starve_idle", 1'b0, 5'd6, 32'h206, 0);

    // Reset mid-operation with two buffered entries: they must never appear.
    drive(1'b1, 5'd1, 32'h301, 1'b1, 5'd20, 32'hB0);
    check_pre("midrst_a", 1'b1, 1'b0);
    check_post("midrst_a", 1'b1, 5'd1, 32'h301, 1);
    drive(1'b1, 5'd2, 32'h302, 1'b1, 5'd21, 32'hB1);
    check_pre("midrst_b", 1'b1, 1'b0);
    check_post("midrst_b", 1'b1, 5'd2, 32'h302, 2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    check_pre("midrst_rst", 1'b0, 1'b0);
    check_post("midrst_rst", 1'b0, 5'd0, 32'h0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_pre($sformatf("midrst_after%0d", k), 1'b1, 1'b0);
      check_post($sformatf("midrst_after%0d", k), 1'b0, 5'd0, 32'h0, 0);
    end

    // Random traffic against a queue model of the arbitration rules.
    mq.delete();
    m_starve = 0;
    m_we = 1'b0;
    m_rd = 5'd0;
    m_data = 32'h0;
    begin
      logic hold_wb, hold_mdu;
      logic e_ready, e_stall, wbr, fr, fw;
      ent_t head;
      hold_wb  = 1'b0;
      hold_mdu = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if (!hold_wb) begin
          wb_en   = ($urandom_range(0, 9) < 7);
          wb_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          wb_data = $urandom;
        end
        if (!hold_mdu) begin
          mdu_v    = ($urandom_range(0, 9) < 5);
          mdu_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          mdu_data = $urandom;
        end
        rst_n = ($urandom_range(0, 99) != 0);

        wbr = wb_en && (wb_rd != 5'd0);
        fr  = (mq.size() > 0);
        fw  = fr && (!wbr || m_starve >= LIMIT);
        if (!rst_n) begin
          e_ready = 1'b0;
          e_stall = 1'b0;
        end else begin
          e_ready = (mq.size() < DEPTH);
          e_stall = wbr && fw;
        end
        check_pre($sformatf("rnd%0d", c), e_ready, e_stall);

        if (!rst_n) begin
          mq.delete();
          m_starve = 0;
          m_we = 1'b0;
          m_rd = 5'd0;
          m_data = 32'h0;
        end else begin
          if (fw) begin
            head = mq.pop_front();
            m_we = 1'b1;
            m_rd = head.rd;
            m_data = head.data;
            m_starve = 0;
          end else if (wbr) begin
            m_we = 1'b1;
            m_rd = wb_rd;
            m_data = wb_data;
            m_starve = fr ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
          end else begin
            m_we = 1'b0;
            m_starve = 0;
          end
          if (mdu_v && e_ready && mdu_rd != 5'd0) begin
            mq.push_back('{rd: mdu_rd, data: mdu_data});
          end
        end
        hold_wb  = e_stall;
        hold_mdu = rst_n && mdu_v && !e_ready;
        check_post($sformatf("rnd%0d", c), m_we, m_rd, m_data, mq.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
